// File: rtl/alu_pkg.sv
// Shared types, opcodes and result-cleaning helpers for the ALU command sequencer.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT1 = 3'b110;
  localparam logic [2:0] OP_NOT2 = 3'b111;

  // The tag travels beside this struct because its width is a top-level parameter.
  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HOLD  = 2'b10
  } seq_state_t;

  // The ALU divides by the magnitude in bits 14:0, so 0x8000 is also a zero divisor.
  function automatic logic is_div0(input logic [2:0] opcode, input logic [DATA_W-1:0] b);
    return (opcode == OP_DIV) && (b[14:0] == 15'h0000);
  endfunction

  function automatic logic [RES_W-1:0] clean_result(input logic [2:0] opcode,
                                                    input logic       div0,
                                                    input logic [RES_W-1:0] raw);
    logic [RES_W-1:0] res;
    if (div0) begin
      res = {RES_W{1'b0}};
    end else if (opcode[2]) begin
      res = {16'h0000, raw[15:0]};
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Count-based synchronous FIFO holding queued ALU commands; head is read combinationally.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to the combinational ALU and
// returns cleaned, tagged results in command order.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [2:0]        alu_opcode,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_div0
);

  localparam int FW = TAG_W + $bits(alu_cmd_t);

  seq_state_t       state_r;
  logic [TAG_W-1:0] tag_r;
  logic             div0_pend_r;
  alu_cmd_t         in_cmd_s;
  alu_cmd_t         head_cmd_s;
  logic [TAG_W-1:0] head_tag_s;
  logic [FW-1:0]    fifo_din_s;
  logic [FW-1:0]    fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;
  logic [RES_W-1:0] clean_s;

  assign in_cmd_s   = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
  assign fifo_din_s = {cmd_tag, in_cmd_s};
  assign {head_tag_s, head_cmd_s} = fifo_dout_s;

  assign cmd_ready = !fifo_full_s && !rst;
  assign push_s    = cmd_valid && cmd_ready;
  assign clean_s   = clean_result(alu_opcode, div0_pend_r, alu_result);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Head is consumed when idle, or in HOLD on the same cycle the response is taken.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == ST_IDLE) begin
      pop_s = !fifo_empty_s;
    end else if (state_r == ST_HOLD) begin
      pop_s = rsp_ready && !fifo_empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Operand registers feeding the ALU, loaded whenever a command leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_inp1    <= {DATA_W{1'b0}};
      alu_inp2    <= {DATA_W{1'b0}};
      alu_opcode  <= 3'b000;
      tag_r       <= {TAG_W{1'b0}};
      div0_pend_r <= 1'b0;
    end else if (pop_s) begin
      alu_inp1    <= head_cmd_s.a;
      alu_inp2    <= head_cmd_s.b;
      alu_opcode  <= head_cmd_s.opcode;
      tag_r       <= head_tag_s;
      div0_pend_r <= is_div0(head_cmd_s.opcode, head_cmd_s.b);
    end
  end

  // Issue/response FSM; the ALU result is sampled one cycle after the operands load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= {RES_W{1'b0}};
      rsp_tag    <= {TAG_W{1'b0}};
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_div0   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_result <= clean_s;
          rsp_tag    <= tag_r;
          rsp_zero   <= (clean_s == {RES_W{1'b0}});
          rsp_neg    <= clean_s[RES_W-1];
          rsp_div0   <= div0_pend_r;
          rsp_valid  <= 1'b1;
          state_r    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= pop_s ? ST_ISSUE : ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU model.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic [15:0] alu_inp1;
  logic [15:0] alu_inp2;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_zero;
  logic        rsp_neg;
  logic        rsp_div0;

  int total = 0;
  int bad   = 0;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_inp1   (alu_inp1),
    .alu_inp2   (alu_inp2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_div0   (rsp_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: garbage in undefined upper halves and on zero divisors.
  logic signed [31:0] ea, eb;
  logic signed [15:0] a16, b16, q16, r16;
  assign ea  = {{16{alu_inp1[15]}}, alu_inp1};
  assign eb  = {{16{alu_inp2[15]}}, alu_inp2};
  assign a16 = alu_inp1;
  assign b16 = alu_inp2;
  always_comb begin
    alu_result = 32'h0;
    q16 = 16'sh0;
    r16 = 16'sh0;
    case (alu_opcode)
      3'b000: alu_result = ea + eb;
      3'b001: alu_result = ea - eb;
      3'b010: alu_result = ea * eb;
      3'b011: begin
        if (alu_inp2[14:0] == 15'h0) begin
          alu_result = 32'hBAD0BAD0;
        end else begin
          q16 = a16 / b16;
          r16 = a16 % b16;
          alu_result = {q16, r16};
        end
      end
      3'b100: alu_result = {16'hA5A5, alu_inp1 | alu_inp2};
      3'b101: alu_result = {16'hC3C3, alu_inp1 & alu_inp2};
      3'b110: alu_result = {16'h5A5A, ~alu_inp1};
      default: alu_result = {16'h3C3C, ~alu_inp2};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("send_ready", {31'h0, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] res, input logic [3:0] tag,
                         input logic z, input logic n, input logic d0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && !rsp_valid; i++) tick();
    chk({name, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({name, "_result"}, rsp_result, res);
    chk({name, "_flags"}, {24'h0, rsp_tag, 1'b0, rsp_zero, rsp_neg, rsp_div0},
        {24'h0, tag, 1'b0, z, n, d0});
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int last_cyc;
    int cyc;
    int stale;
    logic acc6;
    logic pend;

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = 3'b000; cmd_a = 16'h0; cmd_b = 16'h0; cmd_tag = 4'h0;
    tick(); tick(); tick();
    chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("reset_rsp", {rsp_valid, rsp_zero, rsp_neg, rsp_div0, rsp_tag}, 32'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_alu", {13'h0, alu_opcode, alu_inp1}, 32'h0);
    chk("reset_alu_inp2", {16'h0, alu_inp2}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", {31'h0, cmd_ready}, 32'h1);

    // Add with latency: accept edge, then valid two further edges later.
    send(3'b000, 16'h7FFF, 16'h0001, 4'd3);
    chk("lat_t1", {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("lat_t2", {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("lat_t3", {31'h0, rsp_valid}, 32'h1);
    get_rsp("add", 32'h00008000, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("add_released", {31'h0, rsp_valid}, 32'h0);

    send(3'b011, 16'hFFF9, 16'h0002, 4'd1);
    get_rsp("sdiv", 32'hFFFDFFFF, 4'd1, 1'b0, 1'b1, 1'b0);
    send(3'b011, 16'h0005, 16'h8000, 4'd2);
    get_rsp("div0_8000", 32'h0, 4'd2, 1'b1, 1'b0, 1'b1);
    send(3'b011, 16'h0005, 16'h0000, 4'd4);
    get_rsp("div0_0000", 32'h0, 4'd4, 1'b1, 1'b0, 1'b1);
    send(3'b110, 16'h00FF, 16'h1234, 4'd5);
    get_rsp("not_a", 32'h0000FF00, 4'd5, 1'b0, 1'b0, 1'b0);
    send(3'b010, 16'hFFFE, 16'h0003, 4'd6);
    get_rsp("mul", 32'hFFFFFFFA, 4'd6, 1'b0, 1'b1, 1'b0);
    send(3'b001, 16'h0005, 16'h0005, 4'd7);
    get_rsp("sub_zero", 32'h0, 4'd7, 1'b1, 1'b0, 1'b0);
    send(3'b101, 16'hF0F0, 16'h3C3C, 4'd8);
    get_rsp("and", 32'h00003030, 4'd8, 1'b0, 1'b0, 1'b0);
    send(3'b111, 16'h0000, 16'h0001, 4'd9);
    get_rsp("not_b", 32'h0000FFFE, 4'd9, 1'b0, 1'b0, 1'b0);

    // Backpressure: five accepts fill FIFO plus the issue slot.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_opcode = 3'b000;
      cmd_a = 16'(i); cmd_b = 16'h0010; cmd_tag = 4'(i);
      chk("bp_accept_ready", {31'h0, cmd_ready}, 32'h1);
      tick();
    end
    cmd_a = 16'h0005; cmd_b = 16'h0010; cmd_tag = 4'd5;
    chk("bp_full", {31'h0, cmd_ready}, 32'h0);
    tick(); tick();
    chk("bp_still_full", {31'h0, cmd_ready}, 32'h0);
    rsp_ready = 1'b1;
    got = 0; last_cyc = 0; acc6 = 1'b0;
    for (cyc = 0; cyc < 40 && got < 6; cyc++) begin
      pend = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        chk("bp_tag", {28'h0, rsp_tag}, 32'(got));
        chk("bp_result", rsp_result, 32'(got) + 32'h10);
        if (got > 0) chk("bp_spacing", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        got++;
      end
      tick();
      if (pend) begin
        cmd_valid = 1'b0;
        acc6 = 1'b1;
      end
    end
    chk("bp_count", 32'(got), 32'd6);
    chk("bp_sixth_accepted", {31'h0, acc6}, 32'h1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();

    // Reset while holding a response with two commands queued.
    send(3'b000, 16'h0001, 16'h0001, 4'd7);
    send(3'b000, 16'h0002, 16'h0002, 4'd8);
    send(3'b000, 16'h0003, 16'h0003, 4'd9);
    chk("rst_mid_holding", {31'h0, rsp_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_mid_result", rsp_result, 32'h0);
    rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);
    rsp_ready = 1'b0;
    send(3'b100, 16'h1200, 16'h0034, 4'd10);
    get_rsp("post_rst_or", 32'h00001234, 4'd10, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
